// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit sitting beside the ALU in EX.
// Define MDU_FAST_MUL_EN to replace the 32-step multiplier with a single-cycle 33x33 signed multiply.
module mdu #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic            i_flush,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [1:0]  funct_q;
    logic        neg_res_q;
    logic        neg_rem_q;
    logic        special_q;
    logic [31:0] special_res_q;
    logic [63:0] prod_q;
    logic [31:0] mcand_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] divisor_q;

    logic        op1_signed, op2_signed, neg1, neg2;
    logic [31:0] mag1, mag2;
    logic        div_zero, div_ovf, special;
    logic [31:0] special_res;

    // Operand decode at accept: signedness, magnitudes and the two divide corner cases.
    always_comb begin
        op1_signed = 1'b0;
        op2_signed = 1'b0;
        case (i_funct3)
            3'b001, 3'b100, 3'b110: begin
                op1_signed = 1'b1;
                op2_signed = 1'b1;
            end
            3'b010:  op1_signed = 1'b1;
            default: ;
        endcase
        neg1     = op1_signed & i_op1[31];
        neg2     = op2_signed & i_op2[31];
        mag1     = neg1 ? -i_op1 : i_op1;
        mag2     = neg2 ? -i_op2 : i_op2;
        div_zero = i_funct3[2] && (i_op2 == 32'h0);
        div_ovf  = i_funct3[2] && !i_funct3[0] &&
                   (i_op1 == 32'h8000_0000) && (i_op2 == 32'hFFFF_FFFF);
        special  = div_zero | div_ovf;
        if (div_zero)
            special_res = i_funct3[1] ? i_op1 : 32'hFFFF_FFFF;
        else
            special_res = i_funct3[1] ? 32'h0 : 32'h8000_0000;
    end

    logic [32:0] mul_sum;
    logic [63:0] mul_next, mul_signed;
    logic [31:0] mul_res;
    logic [32:0] div_shift, div_diff;
    logic        div_ge;
    logic [31:0] rem_next, quo_next, rem_signed, quo_signed, div_res;

    // One shift-add and one restoring-divide step; the final step's result feeds sign fix-up directly.
    always_comb begin
        mul_sum    = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'h0);
        mul_next   = {mul_sum, prod_q[31:1]};
        mul_signed = neg_res_q ? -mul_next : mul_next;
        mul_res    = (funct_q == 2'b00) ? mul_signed[31:0] : mul_signed[63:32];

        div_shift  = {rem_q, quo_q[31]};
        div_ge     = div_shift >= {1'b0, divisor_q};
        div_diff   = div_shift - {1'b0, divisor_q};
        rem_next   = div_ge ? div_diff[31:0] : div_shift[31:0];
        quo_next   = {quo_q[30:0], div_ge};
        rem_signed = neg_rem_q ? -rem_next : rem_next;
        quo_signed = neg_res_q ? -quo_next : quo_next;
        div_res    = special_q ? special_res_q : (funct_q[1] ? rem_signed : quo_signed);
    end

`ifdef MDU_FAST_MUL_EN
    logic signed [32:0] fast_a, fast_b;
    logic signed [65:0] fast_prod;
    logic [31:0]        fast_res;

    always_comb begin
        fast_a    = {op1_signed & i_op1[31], i_op1};
        fast_b    = {op2_signed & i_op2[31], i_op2};
        fast_prod = fast_a * fast_b;
        fast_res  = (i_funct3[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
    end

    logic unused_bits;
    assign unused_bits = ^{div_diff[32], fast_prod[65:64]};
`else
    logic unused_bits;
    assign unused_bits = div_diff[32];
`endif

    // Control FSM; o_valid and o_result are registered so o_valid is high exactly in DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            count         <= 5'd0;
            o_valid       <= 1'b0;
            o_result      <= 32'h0;
            funct_q       <= 2'b00;
            neg_res_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= 32'h0;
            prod_q        <= 64'h0;
            mcand_q       <= 32'h0;
            rem_q         <= 32'h0;
            quo_q         <= 32'h0;
            divisor_q     <= 32'h0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid && !i_flush) begin
                        funct_q       <= i_funct3[1:0];
                        neg_res_q     <= neg1 ^ neg2;
                        neg_rem_q     <= neg1;
                        special_q     <= special;
                        special_res_q <= special_res;
                        count         <= 5'd0;
                        if (!i_funct3[2]) begin
`ifdef MDU_FAST_MUL_EN
                            o_result <= fast_res;
                            o_valid  <= 1'b1;
                            state    <= DONE;
`else
                            prod_q  <= {32'h0, mag2};
                            mcand_q <= mag1;
                            state   <= MUL;
`endif
                        end else if (EARLY_OUT && special) begin
                            o_result <= special_res;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            rem_q     <= 32'h0;
                            quo_q     <= mag1;
                            divisor_q <= mag2;
                            state     <= DIV;
                        end
                    end
                end
                MUL: begin
                    if (i_flush) begin
                        state <= IDLE;
                    end else begin
                        prod_q <= mul_next;
                        count  <= count + 5'd1;
                        if (count == 5'd31) begin
                            o_result <= mul_res;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DIV: begin
                    if (i_flush) begin
                        state <= IDLE;
                    end else begin
                        rem_q  <= rem_next;
                        quo_q  <= quo_next;
                        count  <= count + 5'd1;
                        if (count == 5'd31) begin
                            o_result <= div_res;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready = (state == IDLE);
    assign o_busy  = ~o_ready;

endmodule
